// File: rtl/orientation_histogram.sv
// SIFT descriptor orientation histogram: scans a PATCH_SIZE^2 gradient patch and writes one packed
// NUM_BINS histogram per subpatch. Define HIST_MAGNITUDE_WEIGHT_EN to weight bins by |gx|+|gy|.
module orientation_histogram #(
  parameter int DIMENSION     = 64,
  parameter int BIT_DEPTH     = 8,
  parameter int PATCH_SIZE    = 8,
  parameter int SUBPATCH_SIZE = 4,
  parameter int NUM_BINS      = 8,
  parameter int READ_LATENCY  = 2,
  localparam int NSUB = (PATCH_SIZE / SUBPATCH_SIZE) * (PATCH_SIZE / SUBPATCH_SIZE),
`ifdef HIST_MAGNITUDE_WEIGHT_EN
  localparam int BIN_W = BIT_DEPTH + 1 + $clog2(SUBPATCH_SIZE * SUBPATCH_SIZE),
`else
  localparam int BIN_W = $clog2(SUBPATCH_SIZE * SUBPATCH_SIZE + 1),
`endif
  localparam int CW  = $clog2(DIMENSION),
  localparam int AW  = $clog2(DIMENSION * DIMENSION),
  localparam int HAW = (NSUB > 1) ? $clog2(NSUB) : 1
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic [CW-1:0]                 x,
  input  logic [CW-1:0]                 y,
  input  logic signed [BIT_DEPTH-1:0]   x_grad,
  input  logic signed [BIT_DEPTH-1:0]   y_grad,
  output logic [AW-1:0]                 x_grad_address,
  output logic [AW-1:0]                 y_grad_address,
  output logic                          wea,
  output logic [HAW-1:0]                histogram_addr,
  output logic [NUM_BINS*BIN_W-1:0]     histogram_out,
  output logic                          busy,
  output logic                          histogram_done
);
  localparam int NPS = PATCH_SIZE / SUBPATCH_SIZE;
  localparam int SW  = (SUBPATCH_SIZE > 1) ? $clog2(SUBPATCH_SIZE) : 1;
  localparam int QW  = (NPS > 1) ? $clog2(NPS) : 1;
  localparam int DW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int XW  = $clog2(DIMENSION + PATCH_SIZE);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]  x_reg, y_reg;
  logic [SW-1:0]  pc_reg, pr_reg;
  logic [QW-1:0]  sc_reg, sr_reg;
  logic [HAW-1:0] sub_reg;
  logic [DW-1:0]  drain_reg;
  logic [AW-1:0]  addr_hold_reg;
  logic           tag_reg [READ_LATENCY];
  logic [BIN_W-1:0] acc_reg [NUM_BINS];

  logic pix_last, drain_last, sub_last, sub_col_last;
  logic [XW-1:0] row, col;
  logic in_range, issue;
  logic [AW-1:0] addr_calc;

  assign pix_last     = (pc_reg == SW'(SUBPATCH_SIZE - 1)) && (pr_reg == SW'(SUBPATCH_SIZE - 1));
  assign drain_last   = (drain_reg == DW'(READ_LATENCY - 1));
  assign sub_last     = (sub_reg == HAW'(NSUB - 1));
  assign sub_col_last = (sc_reg == QW'(NPS - 1));

  assign row       = XW'(y_reg) + XW'(sr_reg) * XW'(SUBPATCH_SIZE) + XW'(pr_reg);
  assign col       = XW'(x_reg) + XW'(sc_reg) * XW'(SUBPATCH_SIZE) + XW'(pc_reg);
  assign in_range  = (row < XW'(DIMENSION)) && (col < XW'(DIMENSION));
  assign issue     = (state_reg == FETCH) && in_range;
  assign addr_calc = AW'(row) * AW'(DIMENSION) + AW'(col);

  always_ff @(posedge clk) begin
    if (rst_in) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (pix_last) state_next = DRAIN;
      DRAIN:   if (drain_last) state_next = WRITE;
      WRITE:   state_next = sub_last ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      x_reg         <= '0;
      y_reg         <= '0;
      pc_reg        <= '0;
      pr_reg        <= '0;
      sc_reg        <= '0;
      sr_reg        <= '0;
      sub_reg       <= '0;
      drain_reg     <= '0;
      addr_hold_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          x_reg     <= x;
          y_reg     <= y;
          pc_reg    <= '0;
          pr_reg    <= '0;
          sc_reg    <= '0;
          sr_reg    <= '0;
          sub_reg   <= '0;
          drain_reg <= '0;
        end
        FETCH: begin
          // clipped pixels leave the address bus parked on the last real address
          if (in_range) addr_hold_reg <= addr_calc;
          if (pc_reg == SW'(SUBPATCH_SIZE - 1)) begin
            pc_reg <= '0;
            pr_reg <= (pr_reg == SW'(SUBPATCH_SIZE - 1)) ? '0 : pr_reg + 1'b1;
          end else begin
            pc_reg <= pc_reg + 1'b1;
          end
        end
        DRAIN: drain_reg <= drain_reg + 1'b1;
        WRITE: begin
          drain_reg <= '0;
          sub_reg   <= sub_reg + 1'b1;
          if (sub_col_last) begin
            sc_reg <= '0;
            sr_reg <= sr_reg + 1'b1;
          end else begin
            sc_reg <= sc_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // valid tag travels alongside the BRAM read so data is binned exactly when it arrives
  always_ff @(posedge clk) begin
    if (rst_in) tag_reg[0] <= 1'b0;
    else        tag_reg[0] <= issue;
  end

  genvar gi;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst_in) tag_reg[gi] <= 1'b0;
        else        tag_reg[gi] <= tag_reg[gi-1];
      end
    end
  endgenerate

  logic sx, sy, gxz, gyz, gxp, gyp, h, hit;
  logic [BIT_DEPTH:0] gxe, gye, a, b;
  logic [1:0] q;
  logic [2:0] bin_sel;
  logic [BIN_W-1:0] inc;

  always_comb begin
    sx  = x_grad[BIT_DEPTH-1];
    sy  = y_grad[BIT_DEPTH-1];
    gxz = (x_grad == '0);
    gyz = (y_grad == '0);
    gxp = !sx && !gxz;
    gyp = !sy && !gyz;
    gxe = {x_grad[BIT_DEPTH-1], x_grad};
    gye = {y_grad[BIT_DEPTH-1], y_grad};
    a   = sx ? (~gxe + 1'b1) : gxe;
    b   = sy ? (~gye + 1'b1) : gye;
    if (gxp && !sy)      q = 2'd0;
    else if (!gxp && gyp) q = 2'd1;
    else if (sx && !gyp) q = 2'd2;
    else                 q = 2'd3;
    h       = q[0] ? (a >= b) : (b >= a);
    bin_sel = (NUM_BINS == 8) ? {q, h} : {1'b0, q};
    hit     = tag_reg[READ_LATENCY-1] && !(gxz && gyz);
`ifdef HIST_MAGNITUDE_WEIGHT_EN
    inc = BIN_W'(a) + BIN_W'(b);
`else
    inc = BIN_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BINS; i++) begin
      if (rst_in || state_reg == WRITE) acc_reg[i] <= '0;
      else if (hit && bin_sel == 3'(i))  acc_reg[i] <= acc_reg[i] + inc;
    end
  end

  generate
    for (gi = 0; gi < NUM_BINS; gi++) begin : g_out
      assign histogram_out[gi*BIN_W +: BIN_W] = (state_reg == WRITE) ? acc_reg[gi] : '0;
    end
  endgenerate

  assign x_grad_address = issue ? addr_calc : addr_hold_reg;
  assign y_grad_address = x_grad_address;
  assign wea            = (state_reg == WRITE);
  assign histogram_addr = wea ? sub_reg : '0;
  assign busy           = (state_reg == FETCH) || (state_reg == DRAIN) || (state_reg == WRITE);
  assign histogram_done = (state_reg == DONE);
endmodule

// File: tb/tb_orientation_histogram.sv
// Scoreboard bench for orientation_histogram: angle-based reference model, BRAM model, monitor.
module tb_orientation_histogram;
  localparam int DIM = 64, BD = 8, PS = 8, SS = 4, NB = 8, RL = 2;
  localparam int NPS = PS / SS, NSUB = NPS * NPS, PER = SS * SS + RL + 1, TOTAL = NSUB * PER + 1;
`ifdef HIST_MAGNITUDE_WEIGHT_EN
  localparam int BIN_W = BD + 1 + $clog2(SS * SS);
`else
  localparam int BIN_W = $clog2(SS * SS + 1);
`endif
  localparam int HW = NB * BIN_W;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic start = 1'b0;
  logic [5:0] x = '0, y = '0;
  logic signed [7:0] x_grad, y_grad;
  logic [11:0] x_grad_address, y_grad_address;
  logic wea, busy, histogram_done;
  logic [1:0] histogram_addr;
  logic [HW-1:0] histogram_out;

  always #5 clk = ~clk;

  orientation_histogram #(
    .DIMENSION(DIM), .BIT_DEPTH(BD), .PATCH_SIZE(PS), .SUBPATCH_SIZE(SS),
    .NUM_BINS(NB), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .x(x), .y(y),
    .x_grad(x_grad), .y_grad(y_grad),
    .x_grad_address(x_grad_address), .y_grad_address(y_grad_address),
    .wea(wea), .histogram_addr(histogram_addr), .histogram_out(histogram_out),
    .busy(busy), .histogram_done(histogram_done)
  );

  logic signed [7:0] gx_mem [DIM*DIM];
  logic signed [7:0] gy_mem [DIM*DIM];
  logic signed [7:0] gx_pipe [RL];
  logic signed [7:0] gy_pipe [RL];

  always @(posedge clk) begin
    gx_pipe[0] <= gx_mem[x_grad_address];
    gy_pipe[0] <= gy_mem[y_grad_address];
    for (int i = 1; i < RL; i++) begin
      gx_pipe[i] <= gx_pipe[i-1];
      gy_pipe[i] <= gy_pipe[i-1];
    end
  end
  assign x_grad = gx_pipe[RL-1];
  assign y_grad = gy_pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  typedef struct { int a; int c; logic [HW-1:0] d; } hist_t;
  typedef struct { int c; int a; } addr_t;
  hist_t hist_q[$];
  addr_t addr_q[$];
  int done_q[$];
  int m_hold = 0;

  // orientation sector from the true angle in [0,360); the tiny offset resolves exact sector edges upward
  function automatic int model_bin(int gx, int gy);
    real ang;
    if (gx == 0 && gy == 0) return -1;
    ang = $atan2(real'(gy), real'(gx)) * 180.0 / 3.14159265358979;
    if (ang < 0.0) ang = ang + 360.0;
    ang = ang + 1.0e-6;
    return int'($floor(ang / (360.0 / NB))) % NB;
  endfunction

  function automatic int weight(int gx, int gy);
`ifdef HIST_MAGNITUDE_WEIGHT_EN
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`else
    return 1;
`endif
  endfunction

  task automatic expect_run(int px, int py, int c0);
    int cnt[NB];
    logic [HW-1:0] pk;
    int row, col, gx, gy, bn, s, p;
    for (s = 0; s < NSUB; s++) begin
      foreach (cnt[i]) cnt[i] = 0;
      for (p = 0; p < SS * SS; p++) begin
        row = py + (s / NPS) * SS + p / SS;
        col = px + (s % NPS) * SS + p % SS;
        if (row < DIM && col < DIM) begin
          gx = gx_mem[row*DIM+col];
          gy = gy_mem[row*DIM+col];
          bn = model_bin(gx, gy);
          if (bn >= 0) cnt[bn] += weight(gx, gy);
        end
      end
      pk = '0;
      for (int i = 0; i < NB; i++) pk[i*BIN_W +: BIN_W] = BIN_W'(cnt[i]);
      hist_q.push_back('{s, c0 + (s + 1) * PER, pk});
    end
    for (int k = 1; k < TOTAL; k++) begin
      s = (k - 1) / PER;
      p = (k - 1) % PER;
      if (p < SS * SS) begin
        row = py + (s / NPS) * SS + p / SS;
        col = px + (s % NPS) * SS + p % SS;
        if (row < DIM && col < DIM) m_hold = row * DIM + col;
      end
      addr_q.push_back('{c0 + k, m_hold});
    end
    done_q.push_back(c0 + TOTAL);
  endtask

  always @(negedge clk) begin
    if (!rst_in) begin
      total++;
      if (x_grad_address !== y_grad_address) begin
        bad++;
        $display("FAIL addr_equal cyc=%0d x_addr=%0d y_addr=%0d", cyc, x_grad_address, y_grad_address);
      end
      while (addr_q.size() != 0 && addr_q[0].c == cyc) begin
        addr_t e;
        e = addr_q.pop_front();
        total++;
        if (int'(x_grad_address) != e.a) begin
          bad++;
          $display("FAIL addr cyc=%0d got=%0d want=%0d", cyc, x_grad_address, e.a);
        end
      end
      if (wea) begin
        total++;
        if (hist_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write cyc=%0d addr=%0d", cyc, histogram_addr);
        end else begin
          hist_t e;
          e = hist_q.pop_front();
          if (int'(histogram_addr) != e.a || histogram_out !== e.d || cyc != e.c || !busy) begin
            bad++;
            $display("FAIL write cyc=%0d/%0d addr=%0d/%0d busy=%0b got=%h want=%h",
                     cyc, e.c, histogram_addr, e.a, busy, histogram_out, e.d);
          end
        end
      end
      if (histogram_done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          int ec;
          ec = done_q.pop_front();
          if (cyc != ec || busy) begin
            bad++;
            $display("FAIL done cyc got=%0d want=%0d busy=%0b", cyc, ec, busy);
          end
        end
      end
    end
  end

  task automatic chk(string name, longint got, longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_wea"}, longint'(wea), 0);
    chk({tag, "_done"}, longint'(histogram_done), 0);
    chk({tag, "_xaddr"}, longint'(x_grad_address), 0);
    chk({tag, "_haddr"}, longint'(histogram_addr), 0);
    chk({tag, "_hout_nonzero"}, longint'(|histogram_out), 0);
  endtask

  int specials[7] = '{0, -128, 127, 1, -1, 3, -3};
  function automatic int rnd_grad();
    if ($urandom_range(0, 4) == 0) return specials[$urandom_range(0, 6)];
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic fill(bit rnd, int gx, int gy);
    for (int i = 0; i < DIM * DIM; i++) begin
      gx_mem[i] = rnd ? 8'(rnd_grad()) : 8'(gx);
      gy_mem[i] = rnd ? 8'(rnd_grad()) : 8'(gy);
    end
  endtask

  task automatic run(int px, int py, bit poke);
    expect_run(px, py, cyc);
    x = 6'(px);
    y = 6'(py);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      x = ~x;
      y = ~y;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < TOTAL + 20 && done_q.size() != 0; i++) @(posedge clk);
    #1;
    total++;
    if (done_q.size() != 0 || hist_q.size() != 0) begin
      bad++;
      $display("FAIL run_complete x=%0d y=%0d pending_done=%0d pending_writes=%0d",
               px, py, done_q.size(), hist_q.size());
    end
    done_q.delete();
    hist_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int cx[6] = '{3, 0, -3, -128, 0, 0};
  int cy[6] = '{3, 4, 3, 0, -7, 0};

  initial begin
    fill(1'b0, 0, 0);
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_in = 1'b0;

    fill(1'b0, 5, 0);
    run(0, 0, 1'b0);

    fill(1'b1, 0, 0);
    run(2, 3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      fill(1'b0, 0, 0);
      gx_mem[(16 + i) * DIM + 16 + i] = 8'(cx[i]);
      gy_mem[(16 + i) * DIM + 16 + i] = 8'(cy[i]);
      run(16, 16, 1'b0);
    end

    fill(1'b0, 1, 1);
    run(60, 60, 1'b0);

    repeat (8) begin
      fill(1'b1, 0, 0);
      run(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
    end

    fill(1'b1, 0, 0);
    run(5, 9, 1'b1);

    // abort in the middle of the first drain, then confirm silence and a clean restart
    x = 6'd7;
    y = 6'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_in = 1'b1;
    @(posedge clk); #1;
    m_hold = 0;
    check_idle_outputs("abort");
    rst_in = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    run(7, 7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
